exe_stage: RTL and testbench

Execute stage of the ARM968E-S-subset pipeline: consumes the ID/EX register outputs, generates the second operand (Val2), runs the ALU, owns the NZCV status register fed back to the decode stage, resolves branch target and taken signal for fetch, and registers results into the EX/MEM pipeline register. It sits directly downstream of the decode stage and its ID/EX register, and upstream of the memory stage.

---
 rtl/exe_stage.sv | 128 ++++++++++++
 tb/tb_exe_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU, NZCV status register, branch target
// resolution and the EX/MEM pipeline register.
module exe_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        WB_EN_in,
   input  logic        MEM_R_EN_in,
   input  logic        MEM_W_EN_in,
   input  logic [3:0]  EXE_CMD,
   input  logic        B,
   input  logic        S,
   input  logic [31:0] PC_in,
   input  logic [31:0] Val_Rn,
   input  logic [31:0] Val_Rm,
   input  logic        imm,
   input  logic [11:0] Shift_Operand,
   input  logic [23:0] Signed_imm_24,
   input  logic [3:0]  Dest_in,
   output logic [3:0]  SR,
   output logic        branch_taken,
   output logic [31:0] branch_address,
   output logic        WB_EN,
   output logic        MEM_R_EN,
   output logic        MEM_W_EN,
   output logic [31:0] ALU_Res,
   output logic [31:0] Val_Rm_out,
   output logic [3:0]  Dest
);

   logic [3:0]  r_sr;
   logic        r_wb_en, r_mem_r_en, r_mem_w_en;
   logic [31:0] r_alu_res, r_val_rm;
   logic [3:0]  r_dest;

   logic [4:0]  w_rot, w_amt;
   logic [63:0] w_imm_dbl, w_rm_dbl;
   logic [31:0] w_imm_rot, w_reg_sh, w_val2, w_res;
   logic [32:0] w_sum;
   logic        w_n, w_z, w_c, w_v;

   // Rotations use a doubled word so that an amount of 0 falls out naturally.
   always_comb begin
      w_rot     = {Shift_Operand[11:8], 1'b0};
      w_amt     = Shift_Operand[11:7];
      w_imm_dbl = {24'b0, Shift_Operand[7:0], 24'b0, Shift_Operand[7:0]} >> w_rot;
      w_imm_rot = w_imm_dbl[31:0];
      w_rm_dbl  = {Val_Rm, Val_Rm} >> w_amt;
      case (Shift_Operand[6:5])
         2'b00:   w_reg_sh = Val_Rm << w_amt;
         2'b01:   w_reg_sh = Val_Rm >> w_amt;
         2'b10:   w_reg_sh = 32'($signed(Val_Rm) >>> w_amt);
         default: w_reg_sh = w_rm_dbl[31:0];
      endcase
      if (MEM_R_EN_in || MEM_W_EN_in)
         w_val2 = {20'b0, Shift_Operand};
      else if (imm)
         w_val2 = w_imm_rot;
      else
         w_val2 = w_reg_sh;
   end

   // Logic ops and unknown codes leave C and V at their current values.
   always_comb begin
      w_sum = '0;
      w_res = '0;
      w_c   = r_sr[1];
      w_v   = r_sr[0];
      case (EXE_CMD)
         4'b0001: w_res = w_val2;
         4'b1001: w_res = ~w_val2;
         4'b0010, 4'b0011: begin
            w_sum = {1'b0, Val_Rn} + {1'b0, w_val2}
                    + {32'b0, (EXE_CMD[0] & r_sr[1])};
            w_res = w_sum[31:0];
            w_c   = w_sum[32];
            w_v   = (Val_Rn[31] == w_val2[31]) && (w_res[31] != Val_Rn[31]);
         end
         4'b0100, 4'b0101: begin
            w_sum = {1'b0, Val_Rn} - {1'b0, w_val2}
                    - {32'b0, (EXE_CMD[0] & ~r_sr[1])};
            w_res = w_sum[31:0];
            w_c   = ~w_sum[32];
            w_v   = (Val_Rn[31] != w_val2[31]) && (w_res[31] != Val_Rn[31]);
         end
         4'b0110: w_res = Val_Rn & w_val2;
         4'b0111: w_res = Val_Rn | w_val2;
         4'b1000: w_res = Val_Rn ^ w_val2;
         default: w_res = '0;
      endcase
      w_n = w_res[31];
      w_z = (w_res == 32'b0);
   end

   assign branch_taken   = B;
   assign branch_address = PC_in + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

   // EX/MEM boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr       <= '0;
         r_wb_en    <= 1'b0;
         r_mem_r_en <= 1'b0;
         r_mem_w_en <= 1'b0;
         r_alu_res  <= '0;
         r_val_rm   <= '0;
         r_dest     <= '0;
      end else if (!freeze) begin
         if (S)
            r_sr <= {w_n, w_z, w_c, w_v};
         r_wb_en    <= WB_EN_in;
         r_mem_r_en <= MEM_R_EN_in;
         r_mem_w_en <= MEM_W_EN_in;
         r_alu_res  <= w_res;
         r_val_rm   <= Val_Rm;
         r_dest     <= Dest_in;
      end
   end

   assign SR         = r_sr;
   assign WB_EN      = r_wb_en;
   assign MEM_R_EN   = r_mem_r_en;
   assign MEM_W_EN   = r_mem_w_en;
   assign ALU_Res    = r_alu_res;
   assign Val_Rm_out = r_val_rm;
   assign Dest       = r_dest;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: vector table for ALU/shifter/flags, plus
// hand sequences for reset, branch, freeze and mid-stream reset.
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst, freeze, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B, S, imm;
   logic [3:0]  EXE_CMD, Dest_in;
   logic [31:0] PC_in, Val_Rn, Val_Rm;
   logic [11:0] Shift_Operand;
   logic [23:0] Signed_imm_24;
   logic [3:0]  SR, Dest;
   logic        branch_taken, WB_EN, MEM_R_EN, MEM_W_EN;
   logic [31:0] branch_address, ALU_Res, Val_Rm_out;

   int n_cmp  = 0;
   int n_fail = 0;

   exe_stage dut (
      .clk(clk), .rst(rst), .freeze(freeze),
      .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
      .EXE_CMD(EXE_CMD), .B(B), .S(S), .PC_in(PC_in),
      .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm),
      .Shift_Operand(Shift_Operand), .Signed_imm_24(Signed_imm_24), .Dest_in(Dest_in),
      .SR(SR), .branch_taken(branch_taken), .branch_address(branch_address),
      .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .ALU_Res(ALU_Res), .Val_Rm_out(Val_Rm_out), .Dest(Dest)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cmd;
      logic        s, im, mr, mw, wb;
      logic [31:0] rn, rm;
      logic [11:0] so;
      logic [3:0]  dest;
      logic [31:0] exp_res;
      logic [3:0]  exp_sr;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      EXE_CMD = v.cmd; S = v.s; imm = v.im; MEM_R_EN_in = v.mr; MEM_W_EN_in = v.mw;
      WB_EN_in = v.wb; Val_Rn = v.rn; Val_Rm = v.rm; Shift_Operand = v.so; Dest_in = v.dest;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // cmd, S, imm, mr, mw, wb, Rn, Rm, shift_op, dest, ALU_Res, SR
      tbl[0]  = '{4'b0010, 1, 1, 0, 0, 1, 32'h7FFFFFFF, 32'h11111111, 12'h001, 4'h1, 32'h80000000, 4'b1001};
      tbl[1]  = '{4'b0100, 1, 1, 0, 0, 1, 32'h00000005, 32'h22222222, 12'h005, 4'h2, 32'h00000000, 4'b0110};
      tbl[2]  = '{4'b0011, 0, 1, 0, 0, 1, 32'h00000001, 32'h00000000, 12'h001, 4'h3, 32'h00000003, 4'b0110};
      tbl[3]  = '{4'b0001, 0, 1, 0, 0, 1, 32'h00000000, 32'h00000000, 12'h4FF, 4'h4, 32'hFF000000, 4'b0110};
      tbl[4]  = '{4'b0001, 1, 0, 0, 0, 1, 32'h00000000, 32'h80000000, 12'h0C0, 4'h5, 32'hC0000000, 4'b1010};
      tbl[5]  = '{4'b1001, 1, 1, 0, 0, 1, 32'h00000000, 32'h00000000, 12'h000, 4'h6, 32'hFFFFFFFF, 4'b1010};
      tbl[6]  = '{4'b0101, 1, 1, 0, 0, 1, 32'h0000000A, 32'h00000000, 12'h003, 4'h7, 32'h00000007, 4'b0010};
      tbl[7]  = '{4'b0101, 1, 1, 0, 0, 1, 32'h00000000, 32'h00000000, 12'h001, 4'h8, 32'hFFFFFFFF, 4'b1000};
      tbl[8]  = '{4'b0101, 1, 1, 0, 0, 1, 32'h00000005, 32'h00000000, 12'h002, 4'h9, 32'h00000002, 4'b0010};
      tbl[9]  = '{4'b0011, 1, 1, 0, 0, 1, 32'hFFFFFFFF, 32'h00000000, 12'h000, 4'hA, 32'h00000000, 4'b0110};
      tbl[10] = '{4'b0110, 1, 0, 0, 0, 1, 32'hF0F0F0F0, 32'h0FF00FF0, 12'h000, 4'hB, 32'h00F000F0, 4'b0010};
      tbl[11] = '{4'b0111, 0, 0, 0, 0, 1, 32'h12340000, 32'h0000ABCD, 12'h220, 4'hC, 32'h12340ABC, 4'b0010};
      tbl[12] = '{4'b1000, 1, 0, 0, 0, 1, 32'hFFFF0000, 32'h0000FFFF, 12'h860, 4'hD, 32'h00000000, 4'b0110};
      tbl[13] = '{4'b0001, 1, 0, 0, 0, 1, 32'h00000000, 32'h00000001, 12'hF80, 4'hE, 32'h80000000, 4'b1010};
      tbl[14] = '{4'b0000, 1, 1, 0, 0, 1, 32'h12345678, 32'h00000000, 12'h0FF, 4'hF, 32'h00000000, 4'b0110};
      tbl[15] = '{4'b0010, 0, 1, 1, 0, 1, 32'h00001000, 32'h00000000, 12'h123, 4'h1, 32'h00001123, 4'b0110};
      tbl[16] = '{4'b0100, 1, 1, 0, 0, 1, 32'h80000000, 32'h00000000, 12'h001, 4'h2, 32'h7FFFFFFF, 4'b0011};
      tbl[17] = '{4'b0010, 0, 0, 0, 1, 0, 32'h00002000, 32'hCAFEBABE, 12'h004, 4'h3, 32'h00002004, 4'b0011};

      // Reset with freeze held and arbitrary inputs
      rst = 1'b1; freeze = 1'b1; B = 1'b0; PC_in = '0; Signed_imm_24 = '0;
      EXE_CMD = 4'b0010; S = 1'b1; imm = 1'b0; MEM_R_EN_in = 1'b1; MEM_W_EN_in = 1'b1;
      WB_EN_in = 1'b1; Val_Rn = $urandom; Val_Rm = $urandom;
      Shift_Operand = 12'($urandom); Dest_in = 4'hF;
      tick();
      Val_Rn = $urandom; Val_Rm = $urandom;
      tick();
      chk("reset_alu", ALU_Res, 32'h0);
      chk("reset_sr", SR, 4'h0);
      chk("reset_ctrl", {WB_EN, MEM_R_EN, MEM_W_EN, Dest, Val_Rm_out}, '0);
      rst = 1'b0; freeze = 1'b0;

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i]);
         tick();
         chk($sformatf("vec%0d_alu", i), ALU_Res, tbl[i].exp_res);
         chk($sformatf("vec%0d_sr", i), SR, tbl[i].exp_sr);
         chk($sformatf("vec%0d_pass", i), {WB_EN, MEM_R_EN, MEM_W_EN, Dest, Val_Rm_out},
             {tbl[i].wb, tbl[i].mr, tbl[i].mw, tbl[i].dest, tbl[i].rm});
      end

      // Branch target is combinational
      B = 1'b1; PC_in = 32'h100; Signed_imm_24 = 24'hFFFFFE;
      #1;
      chk("br_taken", branch_taken, 1'b1);
      chk("br_addr_neg", branch_address, 32'h000000F8);
      B = 1'b0; PC_in = 32'h1000; Signed_imm_24 = 24'h000010;
      #1;
      chk("br_not_taken", branch_taken, 1'b0);
      chk("br_addr_pos", branch_address, 32'h00001040);
      PC_in = 32'hFFFFFFFC; Signed_imm_24 = 24'h000001;
      #1;
      chk("br_addr_wrap", branch_address, 32'h00000000);

      // Freeze: load 7, then hold through three frozen ADDS cycles
      EXE_CMD = 4'b0001; S = 1'b1; imm = 1'b1; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
      WB_EN_in = 1'b1; Val_Rn = 32'h0; Val_Rm = 32'h0; Shift_Operand = 12'h007; Dest_in = 4'h4;
      tick();
      chk("frz_load_alu", ALU_Res, 32'h7);
      chk("frz_load_sr", SR, 4'b0011);
      freeze = 1'b1;
      EXE_CMD = 4'b0010; Val_Rn = 32'h1; Shift_Operand = 12'h002; Dest_in = 4'h9; Val_Rm = 32'h55;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("frz%0d_alu", c), ALU_Res, 32'h7);
         chk($sformatf("frz%0d_sr", c), SR, 4'b0011);
         chk($sformatf("frz%0d_dest", c), Dest, 4'h4);
      end
      freeze = 1'b0;
      tick();
      chk("frz_rel_alu", ALU_Res, 32'h3);
      chk("frz_rel_sr", SR, 4'b0000);
      chk("frz_rel_dest", Dest, 4'h9);

      // Reset mid-stream overrides an in-flight instruction
      Val_Rn = 32'h7FFFFFFF; Shift_Operand = 12'h001; Dest_in = 4'hC; Val_Rm = 32'hABCD;
      rst = 1'b1;
      tick();
      chk("mid_rst_alu", ALU_Res, 32'h0);
      chk("mid_rst_sr", SR, 4'h0);
      chk("mid_rst_ctrl", {WB_EN, MEM_R_EN, MEM_W_EN, Dest, Val_Rm_out}, '0);
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
